// File: rtl/inst_rom_ctrl.sv
// -----------------------------------------------------------------------------
// inst_rom_ctrl
//   Instruction-memory responder for the core's fetch port. A fetch request
//   (rom_ce/rom_addr) is accepted in IDLE. Four bytes are then read from a
//   byte-wide synchronous-read memory. They are assembled little-endian into a
//   32-bit word, and the word is returned with a one-cycle rom_valid pulse.
//
//   Build option:
//     ROM_HIT_CACHE_EN - single-entry tag of the last completed fetch. A repeat
//                        request to the same aligned word skips the memory read
//                        and goes straight to DONE.
//
//   Ports:
//     clk        clock, all state updates on the rising edge
//     rst        asynchronous active-low reset
//     rom_ce     fetch request, sampled only in IDLE
//     rom_addr   fetch byte address; [ADDR_W-1:2] used, [1:0] treated as 0
//     rom_data   assembled instruction word, held until the next completion
//     rom_valid  one-cycle pulse marking rom_data as the requested word
//     busy       high whenever the controller is not in IDLE
//     mem_a      byte address to the backing memory
//     mem_re     read strobe, high while mem_a carries a real address
//     mem_din    memory read data, valid the cycle after its address
//     dbg_state  current FSM state (IDLE=0, READ=1, DONE=2)
//
//   Handshake: a request is taken on a rising edge where the controller is in
//   IDLE (busy=0) and rom_ce=1. rom_ce and rom_addr are ignored at every other
//   edge. rom_valid is asserted for exactly one cycle per accepted request,
//   unless a reset intervenes.
// -----------------------------------------------------------------------------
module inst_rom_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce,
    input  logic [31:0]       rom_addr,
    output logic [31:0]       rom_data,
    output logic              rom_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_re,
    input  logic [7:0]        mem_din,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [2:0]        cnt, cnt_nx;
    logic [ADDR_W-1:0] base, base_nx;
    logic [31:0]       shreg, shreg_nx;
    logic [31:0]       rom_data_nx;
    logic [ADDR_W-1:0] req_base;
    logic              hit;

    // Address bits outside the word-aligned memory range are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rom_addr[31:ADDR_W], rom_addr[1:0]};

    assign req_base = {rom_addr[ADDR_W-1:2], 2'b00};

`ifdef ROM_HIT_CACHE_EN
    logic [ADDR_W-1:0] last_base;
    logic              last_ok;

    assign hit = last_ok && (req_base == last_base);

    // The tag is only written when a real memory read completes. A hit
    // therefore never refreshes the tag with data it did not fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_base <= '0;
            last_ok   <= 1'b0;
        end else if (state == READ && cnt == 3'd4) begin
            last_base <= base;
            last_ok   <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            base     <= '0;
            shreg    <= '0;
            rom_data <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            base     <= base_nx;
            shreg    <= shreg_nx;
            rom_data <= rom_data_nx;
        end
    end

    // Next-state and memory-side outputs.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        base_nx     = base;
        shreg_nx    = shreg;
        rom_data_nx = rom_data;
        mem_a       = '0;
        mem_re      = 1'b0;

        case (state)
            IDLE: begin
                if (rom_ce) begin
                    base_nx  = req_base;
                    cnt_nx   = 3'd0;
                    state_nx = hit ? DONE : READ;
                end
            end

            READ: begin
                // cnt 0..3 present addresses. cnt 1..4 collect the byte that
                // was addressed one cycle earlier.
                if (cnt != 3'd4) begin
                    mem_a  = base + ADDR_W'(cnt);
                    mem_re = 1'b1;
                end
                if (cnt != 3'd0) begin
                    // Shift in from the top: after four captures, byte 0
                    // (from base) sits in bits [7:0].
                    shreg_nx = {mem_din, shreg[31:8]};
                end
                if (cnt == 3'd4) begin
                    // The complete word is loaded in one step, so rom_data
                    // never shows a partially assembled word.
                    rom_data_nx = {mem_din, shreg[31:8]};
                    cnt_nx      = 3'd0;
                    state_nx    = DONE;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end

            DONE: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign rom_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
module tb_inst_rom_ctrl;

  localparam int AW = 17;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rom_ce = 1'b0;
  logic [31:0]   rom_addr = 32'h0;
  logic [31:0]   rom_data;
  logic          rom_valid;
  logic          busy;
  logic [AW-1:0] mem_a;
  logic          mem_re;
  logic [7:0]    mem_din = 8'h0;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  inst_rom_ctrl #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rom_ce    (rom_ce),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rom_valid (rom_valid),
    .busy      (busy),
    .mem_a     (mem_a),
    .mem_re    (mem_re),
    .mem_din   (mem_din),
    .dbg_state (dbg_state)
  );

  // Byte-wide synchronous-read memory.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (mem_re) mem_din <= mem[mem_a];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- scoreboard
  int            n_vec = 0;
  int            n_err = 0;
  logic [31:0]   exp_q[$];
  int            lat_q[$];
  int            acc_q[$];
  logic [AW-1:0] addr_q[$];
  logic [31:0]   cur_data = 32'h0;
  logic          m_last_ok = 1'b0;
  logic [AW-1:0] m_last_base = '0;
  logic [31:0]   m_last_word = 32'h0;
  int            prev_valid_cyc = -100;
  int            last_valid_cyc = -100;
  int            busy_run = 0;
  logic [31:0]   mon_w;
  int            mon_l;
  int            mon_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a request is a read of four consecutive bytes at the
  // aligned address. With the hit cache, it is a repeat of the last full read.
  task automatic accept(input logic [31:0] a);
    logic [AW-1:0] b;
    logic [31:0]   w;
    bit            hit;
    b = a[AW-1:0] & ~AW'(3);
    w = {mem[b + AW'(3)], mem[b + AW'(2)], mem[b + AW'(1)], mem[b]};
    hit = 1'b0;
`ifdef ROM_HIT_CACHE_EN
    hit = m_last_ok && (b == m_last_base);
`endif
    acc_q.push_back(cyc + 1);
    if (hit) begin
      exp_q.push_back(m_last_word);
      lat_q.push_back(0);
    end else begin
      exp_q.push_back(w);
      lat_q.push_back(5);
      for (int k = 0; k < 4; k++) addr_q.push_back(b + AW'(k));
      m_last_ok   = 1'b1;
      m_last_base = b;
      m_last_word = w;
    end
  endtask

  // Monitor: checks memory addresses, returned words, latency and busy length.
  always @(negedge clk) begin
    if (busy) busy_run++;
    else busy_run = 0;
    if (rst) begin
      if (mem_re) begin
        if (addr_q.size() == 0) check("mem_re_unexpected", 32'(mem_a), 32'hFFFF_FFFF);
        else check("mem_a", 32'(mem_a), 32'(addr_q.pop_front()));
      end
      if (rom_valid) begin
        if (exp_q.size() == 0) begin
          check("valid_unexpected", 32'd1, 32'd0);
        end else begin
          mon_w = exp_q.pop_front();
          mon_l = lat_q.pop_front();
          mon_a = acc_q.pop_front();
          check("rom_data", rom_data, mon_w);
          check("latency", 32'(cyc - mon_a), 32'(mon_l));
          check("busy_len", 32'(busy_run), 32'(mon_l + 1));
          cur_data = mon_w;
          prev_valid_cyc = last_valid_cyc;
          last_valid_cyc = cyc;
        end
      end else begin
        check("rom_data_hold", rom_data, cur_data);
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // Waits for IDLE while toggling rom_ce and pointing rom_addr at 0x200 during
  // busy cycles, then presents the real request for exactly one edge.
  task automatic issue(input logic [31:0] a);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (busy) begin
        rom_ce   = 1'($urandom_range(0, 1));
        rom_addr = 32'h0000_0200;
      end else begin
        rom_ce   = 1'b1;
        rom_addr = a;
        accept(a);
        done = 1'b1;
      end
    end
    if (!done) check("issue_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    rom_ce   = 1'b0;
    rom_addr = $urandom;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    rom_ce = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_data"}, rom_data, 32'h0);
    check({tag, "_rom_valid"}, 32'(rom_valid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_mem_a"}, 32'(mem_a), 32'h0);
    check({tag, "_mem_re"}, 32'(mem_re), 32'h0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    mem[17'h100] = 8'h13; mem[17'h101] = 8'h05; mem[17'h102] = 8'h10; mem[17'h103] = 8'h00;
    mem[17'h004] = 8'hEF; mem[17'h005] = 8'hBE; mem[17'h006] = 8'hAD; mem[17'h007] = 8'hDE;

    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Basic aligned fetch, then an unaligned one to the same word.
    issue(32'h0000_0100);
    drain();
    check("word_0x100", rom_data, 32'h0010_0513);
    issue(32'h0000_0102);
    drain();
    check("word_0x102", rom_data, 32'h0010_0513);

    // Reset while cnt==2: the fetch is abandoned without a valid pulse.
    issue(32'h0000_0008);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete(); lat_q.delete(); acc_q.delete(); addr_q.delete();
    cur_data  = 32'h0;
    m_last_ok = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Fresh fetch after reset, with 0x200 garbage presented while it is busy.
    issue(32'h0000_0100);
    issue(32'h0000_0200);
    drain();
    issue(32'h0000_0100);
    issue(32'h0000_0104);
    drain();

    // rom_ce held high: back-to-back fetches of 0x0 and 0x4.
    n = 0;
    for (int k = 0; k < 60 && n < 2; k++) begin
      @(negedge clk);
      if (!busy) begin
        rom_ce   = 1'b1;
        rom_addr = (n == 0) ? 32'h0 : 32'h4;
        accept(rom_addr);
        n++;
      end
    end
    if (n < 2) check("hold_timeout", 32'(n), 32'd2);
    @(posedge clk);
    #1;
    rom_ce = 1'b0;
    drain();
    check("hold_word", rom_data, 32'hDEAD_BEEF);
    check("hold_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd7);

    // Random requests in a small window (repeats exercise the hit path),
    // with random upper address bits that must be ignored.
    for (int i = 0; i < 30; i++) begin
      issue(($urandom & 32'hFFFE_0000) | 32'($urandom_range(0, 63)));
      if ($urandom_range(0, 2) == 0) begin
        drain();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    drain();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("addr_q_empty", 32'(addr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_rom_ctrl.md
Name: inst_rom_ctrl

Overview:
- Instruction-memory responder on the core's fetch port. It is the serving end of the rom_ce / rom_addr / rom_data interface.
- Accepts a fetch request and reads four bytes from a byte-wide synchronous-read memory.
- Assembles the bytes little-endian into a 32-bit instruction word.
- Returns the word with a one-cycle valid pulse; busy tells the fetch side when it must stall.

Parameters:
ADDR_W, 17, byte-address width of the backing memory (default 128 KiB)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-low
rom_ce  input  1  fetch request; sampled only in IDLE
rom_addr  input  32  fetch byte address; bits [ADDR_W-1:2] used, [1:0] forced to 0
rom_data  output  32  assembled instruction word; held until the next completed fetch
rom_valid  output  1  one-cycle pulse: rom_data holds the word for the last accepted request
busy  output  1  high whenever state != IDLE
mem_a  output  ADDR_W  byte address to the backing memory (combinational from state/counter)
mem_re  output  1  read strobe, high while mem_a carries a real address
mem_din  input  8  read data; valid in the cycle after its address was presented

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, base=0.
  - rom_data=0, rom_valid=0, busy=0, mem_a=0, mem_re=0.
  - Any fetch in progress is abandoned; no valid pulse is produced for it.
- States are IDLE, READ and DONE.
- IDLE:
  - mem_re=0, mem_a=0.
  - Edge with rom_ce=1: base <= {rom_addr[ADDR_W-1:2],2'b00}, cnt <= 0, go to READ. This is acceptance edge T.
  - rom_ce=0: stay in IDLE.
- READ (cnt 0..4):
  - cnt 0..3: mem_a = base+cnt, mem_re=1. The sum wraps modulo 2^ADDR_W, but base is aligned, so the four addresses never wrap.
  - cnt 4: mem_re=0, mem_a=0.
  - At each edge with cnt in 1..4: byte (cnt-1) <= mem_din, placed at bits [8*(cnt-1)+7 : 8*(cnt-1)]. Byte 0 comes from base and is the LSB.
  - At the edge with cnt==4: rom_data <= assembled word, rom_valid <= 1, go to DONE. This is edge T+5.
  - Otherwise cnt <= cnt+1.
- DONE: lasts exactly one cycle, in which rom_valid=1. Next edge: rom_valid <= 0, go to IDLE.
- Latency:
  - rom_valid is high in the cycle after edge T+5.
  - The next request can be accepted at edge T+7 at the earliest; throughput is one word per 7 cycles.
- rom_ce and rom_addr are ignored outside IDLE. Changes mid-fetch do not affect the word in flight.
- rom_ce held high continuously yields back-to-back fetches, each re-sampling rom_addr in IDLE.
- rom_data is stable except at the completing edge. It is never partially updated; bytes are staged in an internal shift register.
- rom_addr bits above ADDR_W-1 are ignored.

Optional Feature:
ROM_HIT_CACHE_EN:
- Defined:
  - Keep a single-entry tag last_base and a bit last_ok, both cleared by reset.
  - Each completed READ sets last_base=base and last_ok=1.
  - In IDLE, rom_ce=1 with last_ok=1 and aligned address equal to last_base is a hit: go directly to DONE. rom_data is unchanged, rom_valid pulses in the cycle after acceptance, and mem_re stays 0.
  - A miss behaves exactly as the baseline.
- Not defined: no tag logic; every request takes the full READ path.

Test Plan:
- Reset with rst=0, then release; mem bytes [0x100..0x103]=13,05,10,00; rom_ce=1, rom_addr=0x100 for one cycle -> mem_a sequence 0x100..0x103 with mem_re=1; rom_valid pulses once 5 edges after acceptance; rom_data=0x00100513; busy high for 6 cycles.
- Unaligned request rom_addr=0x102 -> same mem_a sequence 0x100..0x103; rom_data=0x00100513.
- During READ, change rom_addr to 0x200 and toggle rom_ce -> word for 0x100 still returned; the 0x200 request is taken only when rom_ce is high in IDLE.
- Assert rst=0 at cnt=2, then release -> all outputs 0 immediately; no rom_valid pulse; next request fetches correctly from cnt 0.
- rom_ce held high; addresses 0x0 then 0x4 with bytes 0xEF,0xBE,0xAD,0xDE at 0x4 -> two pulses 7 cycles apart; second rom_data=0xDEADBEEF.
- With ROM_HIT_CACHE_EN, repeat a request to 0x100 -> rom_valid in the cycle after acceptance, mem_re never asserted, rom_data=0x00100513. A request to 0x104 then takes the full 6-cycle path.
